// File: rtl/transpose_switch_stage.sv
// One registered switch stage of the transpose network: lanes in odd blocks take the across vector shifted down one block when ctrl=1.
// Latency 1 cycle, one vector per cycle, no handshake and no stall.
module transpose_switch_stage #(
  parameter int DATA_W     = 8,
  parameter int N_DOWN     = 4,
  parameter int N_ACROSS   = 4,
  parameter int BLOCK_SIZE = 2,
  parameter int NUM_BLOCKS = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ctrl,
  input  logic [DATA_W-1:0] in_elements_down   [0:N_DOWN-1],
  input  logic [DATA_W-1:0] in_elements_across [0:N_ACROSS-1],
  output logic [DATA_W-1:0] out_elements       [0:N_DOWN-1]
);

  if (N_ACROSS != N_DOWN) begin : g_err_across
    $error("transpose_switch_stage: N_ACROSS (%0d) must equal N_DOWN (%0d)", N_ACROSS, N_DOWN);
  end
  if (BLOCK_SIZE < 1) begin : g_err_block
    $error("transpose_switch_stage: BLOCK_SIZE (%0d) must be at least 1", BLOCK_SIZE);
  end
  if ((NUM_BLOCKS < 2) || (NUM_BLOCKS % 2 != 0)) begin : g_err_nblocks
    $error("transpose_switch_stage: NUM_BLOCKS (%0d) must be even and non-zero", NUM_BLOCKS);
  end
  if (NUM_BLOCKS * BLOCK_SIZE != N_DOWN) begin : g_err_geom
    $error("transpose_switch_stage: NUM_BLOCKS*BLOCK_SIZE (%0d) must equal N_DOWN (%0d)",
           NUM_BLOCKS * BLOCK_SIZE, N_DOWN);
  end

  logic [DATA_W-1:0] next_d [0:N_DOWN-1];
  logic [DATA_W-1:0] out_q  [0:N_DOWN-1];
  // Across elements of odd blocks never reach an output; gathered here only so they are not flagged as dangling.
  logic [N_DOWN-1:0] unused_across_par;

  for (genvar i = 0; i < N_DOWN; i++) begin : g_lane
    if (((i / BLOCK_SIZE) % 2) == 1) begin : g_odd
      assign next_d[i]            = ctrl ? in_elements_across[i-BLOCK_SIZE] : in_elements_down[i];
      assign unused_across_par[i] = ^in_elements_across[i];
    end else begin : g_even
      assign next_d[i]            = in_elements_down[i];
      assign unused_across_par[i] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < N_DOWN; i++) begin
      if (rst) begin
        out_q[i] <= '0;
      end else begin
        out_q[i] <= next_d[i];
      end
    end
  end

  assign out_elements = out_q;

endmodule

// File: tb/tb_transpose_switch_stage.sv
// Self-checking bench for transpose_switch_stage: default 4-lane instance plus an 8-lane, 4-block instance.
// Expected vectors are queued when stimulus is driven and popped one edge later.
module tb_transpose_switch_stage;

  logic       clk;
  logic       rst;
  logic       ctrl4;
  logic [7:0] down4   [0:3];
  logic [7:0] across4 [0:3];
  logic [7:0] out4    [0:3];
  logic       ctrl8;
  logic [7:0] down8   [0:7];
  logic [7:0] across8 [0:7];
  logic [7:0] out8    [0:7];

  int errors = 0;
  int checks = 0;

  logic [31:0] sb4_q[$];
  logic [63:0] sb8_q[$];

  transpose_switch_stage #(
    .DATA_W(8), .N_DOWN(4), .N_ACROSS(4), .BLOCK_SIZE(2), .NUM_BLOCKS(2)
  ) dut4 (
    .clk                (clk),
    .rst                (rst),
    .ctrl               (ctrl4),
    .in_elements_down   (down4),
    .in_elements_across (across4),
    .out_elements       (out4)
  );

  transpose_switch_stage #(
    .DATA_W(8), .N_DOWN(8), .N_ACROSS(8), .BLOCK_SIZE(2), .NUM_BLOCKS(4)
  ) dut8 (
    .clk                (clk),
    .rst                (rst),
    .ctrl               (ctrl8),
    .in_elements_down   (down8),
    .in_elements_across (across8),
    .out_elements       (out8)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Lane 0 lands in the most significant byte so vectors read like the written lists.
  function automatic logic [31:0] pack4();
    logic [31:0] v;
    for (int i = 0; i < 4; i++) v[31-8*i -: 8] = out4[i];
    return v;
  endfunction

  function automatic logic [63:0] pack8();
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[63-8*i -: 8] = out8[i];
    return v;
  endfunction

  task automatic drive4(input logic [31:0] d, input logic [31:0] a, input logic c);
    for (int i = 0; i < 4; i++) begin
      down4[i]   = d[31-8*i -: 8];
      across4[i] = a[31-8*i -: 8];
    end
    ctrl4 = c;
  endtask

  task automatic test_reset();
    logic [31:0] got4, exp4;
    logic [63:0] got8, exp8;
    rst = 1'b1;
    drive4($urandom, $urandom, 1'b1);
    ctrl8 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      down8[i]   = 8'($urandom);
      across8[i] = 8'($urandom);
    end
    sb4_q.push_back(32'h0);
    sb8_q.push_back(64'h0);
    @(posedge clk); #1;
    got4 = pack4(); exp4 = sb4_q.pop_front(); checks++;
    if (got4 !== exp4) begin
      errors++; $display("FAIL reset_out4: got %h expected %h", got4, exp4);
    end
    got8 = pack8(); exp8 = sb8_q.pop_front(); checks++;
    if (got8 !== exp8) begin
      errors++; $display("FAIL reset_out8: got %h expected %h", got8, exp8);
    end
  endtask

  task automatic test_swap();
    logic [31:0] got, exp;
    rst = 1'b0;
    drive4(32'h0C0B2C3C, 32'h0D1D1C3D, 1'b1);
    for (int k = 0; k < 3; k++) begin
      sb4_q.push_back(32'h0C0B0D1D);
      @(posedge clk); #1;
      got = pack4(); exp = sb4_q.pop_front(); checks++;
      if (got !== exp) begin
        errors++; $display("FAIL swap_hold%0d: got %h expected %h", k, got, exp);
      end
    end
  endtask

  task automatic test_pass_through();
    logic [31:0] got, exp;
    drive4(32'h0C0B2C3C, 32'h0D1D1C3D, 1'b0);
    sb4_q.push_back(32'h0C0B2C3C);
    @(posedge clk); #1;
    got = pack4(); exp = sb4_q.pop_front(); checks++;
    if (got !== exp) begin
      errors++; $display("FAIL pass_through: got %h expected %h", got, exp);
    end
  endtask

  task automatic test_toggle(input int cycles, input int rst_cycle);
    logic [31:0] got, exp;
    for (int k = 0; k < cycles; k++) begin
      rst = (k == rst_cycle);
      drive4(32'h0C0B2C3C, 32'h0D1D1C3D, k[0]);
      if (k == rst_cycle)  sb4_q.push_back(32'h0);
      else if (k[0])       sb4_q.push_back(32'h0C0B0D1D);
      else                 sb4_q.push_back(32'h0C0B2C3C);
      @(posedge clk); #1;
      got = pack4(); exp = sb4_q.pop_front(); checks++;
      if (got !== exp) begin
        errors++; $display("FAIL toggle_c%0d: got %h expected %h", k, got, exp);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_params8();
    logic [63:0] got, exp;
    for (int i = 0; i < 8; i++) begin
      down8[i]   = 8'(i);
      across8[i] = 8'(8'h10 + i);
    end
    ctrl8 = 1'b1;
    sb8_q.push_back(64'h0001101104051415);
    @(posedge clk); #1;
    got = pack8(); exp = sb8_q.pop_front(); checks++;
    if (got !== exp) begin
      errors++; $display("FAIL params8_swap: got %h expected %h", got, exp);
    end
    ctrl8 = 1'b0;
    sb8_q.push_back(64'h0001020304050607);
    @(posedge clk); #1;
    got = pack8(); exp = sb8_q.pop_front(); checks++;
    if (got !== exp) begin
      errors++; $display("FAIL params8_pass: got %h expected %h", got, exp);
    end
  endtask

  task automatic test_back_to_back(input int n);
    logic [31:0] got, exp, d, a;
    logic        c;
    for (int k = 0; k < n; k++) begin
      d = $urandom;
      a = $urandom;
      c = 1'($urandom);
      drive4(d, a, c);
      // Lanes 2,3 form the odd block; in swap mode they take across lanes 0,1.
      exp = c ? {d[31:16], a[31:16]} : d;
      sb4_q.push_back(exp);
      @(posedge clk); #1;
      got = pack4(); exp = sb4_q.pop_front(); checks++;
      if (got !== exp) begin
        errors++; $display("FAIL b2b_c%0d: got %h expected %h (ctrl=%0b)", k, got, exp, c);
      end
    end
  endtask

  initial begin
    rst   = 1'b1;
    ctrl4 = 1'b0;
    ctrl8 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      down4[i] = '0; across4[i] = '0;
    end
    for (int i = 0; i < 8; i++) begin
      down8[i] = '0; across8[i] = '0;
    end
    @(posedge clk); #1;
    test_reset();
    test_swap();
    test_pass_through();
    test_toggle(6, -1);
    test_toggle(6, 3);
    test_params8();
    test_back_to_back(20);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
